// File: rtl/adc_capture_seq_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM state encoding,
// logic-level constants and small state-classification helpers.
package adc_capture_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_READY   = 3'd4,
    ST_READOUT = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Minimum cycles spent in FLUSH before wstatus is trusted; covers the
  // one-cycle registration of the final wren plus the controller's latency
  // in dropping wstatus for that write.
  localparam logic [1:0] LP_FLUSH_WAIT = 2'd2;

  // The sequencer counts as busy whenever a capture or readout is in progress.
  function automatic logic is_busy_state(input state_t s);
    return (s != ST_IDLE) && (s != ST_READY);
  endfunction

  // A stored capture exists in READY and while it is being read back.
  function automatic logic is_done_state(input state_t s);
    return (s == ST_READY) || (s == ST_READOUT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/adc_capture_seq_fifo.sv
// Read-return buffer: synchronous first-word-fall-through FIFO. The head word
// is always visible on o_rdata; a pop simply advances the read pointer.
module adc_capture_seq_fifo #(
  parameter int P_WIDTH = 16,
  parameter int P_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr,
  input  logic [P_WIDTH-1:0] i_wdata,
  input  logic               i_rd,
  output logic [P_WIDTH-1:0] o_rdata,
  output logic               o_empty,
  output logic [P_AW:0]      o_count
);

  localparam int            LP_DEPTH   = 1 << P_AW;
  localparam logic [P_AW:0] LP_DEPTH_W = (P_AW + 1)'(LP_DEPTH);

  logic [P_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [P_AW-1:0]    r_wptr;
  logic [P_AW-1:0]    r_rptr;
  logic [P_AW:0]      r_count;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_full  = (r_count == LP_DEPTH_W);
  assign o_empty = (r_count == '0);
  assign w_push  = i_wr & ~w_full;
  assign w_pop   = i_rd & ~o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage array; contents need no reset because r_count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping for simultaneous push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_seq.sv
// ADC capture sequencer in front of sdram_ctrl. Records a triggered run of
// samples to SDRAM from address 0, then streams the run back on request
// through a credit-limited read path and a first-word-fall-through buffer.
module adc_capture_seq
  import adc_capture_seq_pkg::*;
#(
  parameter int P_DATA_NBIT  = 16,
  parameter int P_ADDR_NBIT  = 16,
  parameter int P_RDBUF_AW   = 4,
  parameter int P_WR_RUN_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [P_ADDR_NBIT-1:0] length,
  input  logic                   trig,
  input  logic [P_DATA_NBIT-1:0] adc_data,
  input  logic                   adc_valid,
  input  logic                   start_rd,
  output logic [P_DATA_NBIT-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   wren,
  output logic [P_ADDR_NBIT-1:0] waddr,
  output logic [P_DATA_NBIT-1:0] wdata,
  input  logic                   wstatus,
  output logic                   rd,
  output logic [P_ADDR_NBIT-1:0] raddr,
  input  logic [P_DATA_NBIT-1:0] rdata,
  input  logic                   rdv,
  input  logic                   rstatus
);

  localparam int                      LP_RUN_NBIT = $clog2(P_WR_RUN_MAX + 1);
  localparam logic [LP_RUN_NBIT-1:0]  LP_RUN_MAX  = LP_RUN_NBIT'(P_WR_RUN_MAX);
  localparam logic [P_RDBUF_AW+1:0]   LP_DEPTH_W  = (P_RDBUF_AW + 2)'(1 << P_RDBUF_AW);
  localparam logic [P_ADDR_NBIT-1:0]  LP_ONE      = P_ADDR_NBIT'(1);

  state_t                 r_state;
  state_t                 w_state_next;

  logic [P_ADDR_NBIT-1:0] r_len;
  logic [P_ADDR_NBIT-1:0] r_wptr;
  logic [P_ADDR_NBIT-1:0] r_rptr;
  logic [P_ADDR_NBIT-1:0] r_ocnt;
  logic [LP_RUN_NBIT-1:0] r_run_cnt;
  logic [1:0]             r_flush_cnt;
  logic [P_RDBUF_AW:0]    r_inflight;
  logic                   r_ovf;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_wren;
  logic [P_ADDR_NBIT-1:0] r_waddr;
  logic [P_DATA_NBIT-1:0] r_wdata;
  logic                   r_rd;
  logic [P_ADDR_NBIT-1:0] r_raddr;

  logic                   w_arm_ok;
  logic                   w_arm_take;
  logic                   w_rd_start;
  logic                   w_wr_issue;
  logic                   w_ovf_hit;
  logic                   w_run_full;
  logic                   w_rd_issue;
  logic                   w_credit_ok;
  logic [P_RDBUF_AW+1:0]  w_credit_sum;
  logic                   w_rdv_accept;
  logic                   w_pop;
  logic [P_DATA_NBIT-1:0] w_fifo_rdata;
  logic                   w_fifo_empty;
  logic [P_RDBUF_AW:0]    w_fifo_count;

  assign w_arm_ok   = arm && (length != '0);
  assign w_run_full = (wstatus == LOW) && (r_run_cnt >= LP_RUN_MAX);

  // Reads outstanding in the controller plus words already buffered must
  // stay below the buffer depth, so every returned word has a slot.
  assign w_credit_sum = (P_RDBUF_AW + 2)'(r_inflight) + (P_RDBUF_AW + 2)'(w_fifo_count);
  assign w_credit_ok  = (w_credit_sum < LP_DEPTH_W);

  assign w_rdv_accept = rdv && ((r_state == ST_READOUT) || (r_state == ST_DRAIN));
  assign w_pop        = ~w_fifo_empty & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the per-cycle action strobes that go with it.
  always_comb begin
    w_state_next = r_state;
    w_arm_take   = 1'b0;
    w_rd_start   = 1'b0;
    w_wr_issue   = 1'b0;
    w_ovf_hit    = 1'b0;
    w_rd_issue   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm_ok) begin
          w_arm_take   = 1'b1;
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (adc_valid && trig) begin
          if (w_run_full) begin
            w_ovf_hit    = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            w_wr_issue   = 1'b1;
            w_state_next = (r_len == LP_ONE) ? ST_FLUSH : ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (adc_valid) begin
          if (w_run_full) begin
            w_ovf_hit    = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            w_wr_issue = 1'b1;
            if (r_wptr == (r_len - LP_ONE)) begin
              w_state_next = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if ((r_flush_cnt >= LP_FLUSH_WAIT) && (wstatus == HIGH)) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (w_arm_ok) begin
          w_arm_take   = 1'b1;
          w_state_next = ST_ARMED;
        end else if (start_rd) begin
          w_rd_start   = 1'b1;
          w_state_next = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (r_rptr == r_len) begin
          w_state_next = ST_DRAIN;
        end else if (w_credit_ok) begin
          w_rd_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if ((r_ocnt == r_len) && (r_inflight == '0) && (rstatus == HIGH)) begin
          w_state_next = ST_READY;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Capture length, status flags; on overrun the stored length becomes the
  // number of words actually written so readout stops at valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (w_arm_take) begin
        r_len <= length;
        r_ovf <= 1'b0;
      end else if (w_ovf_hit) begin
        r_len <= r_wptr;
        r_ovf <= 1'b1;
      end
      r_done <= is_done_state(w_state_next);
      r_busy <= is_busy_state(w_state_next);
    end
  end

  // Write port: one registered write per accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wren  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wptr  <= '0;
    end else begin
      r_wren <= w_wr_issue;
      if (w_arm_take) begin
        r_wptr <= '0;
      end else if (w_wr_issue) begin
        r_waddr <= r_wptr;
        r_wdata <= adc_data;
        r_wptr  <= r_wptr + LP_ONE;
      end
    end
  end

  // Writes issued since the controller last reported an empty write buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (wstatus == HIGH) begin
      r_run_cnt <= '0;
    end else if (w_wr_issue) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  // Cycles spent in FLUSH, saturating at the required minimum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (r_state != ST_FLUSH) begin
      r_flush_cnt <= '0;
    end else if (r_flush_cnt < LP_FLUSH_WAIT) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Read port, read pointer and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_raddr <= '0;
      r_rptr  <= '0;
      r_ocnt  <= '0;
    end else begin
      r_rd <= w_rd_issue;
      if (w_rd_start) begin
        r_rptr <= '0;
        r_ocnt <= '0;
      end else begin
        if (w_rd_issue) begin
          r_raddr <= r_rptr;
          r_rptr  <= r_rptr + LP_ONE;
        end
        if (w_pop) begin
          r_ocnt <= r_ocnt + LP_ONE;
        end
      end
    end
  end

  // Reads outstanding in the controller; a same-cycle issue and return cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_rd_issue, w_rdv_accept})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  adc_capture_seq_fifo #(
    .P_WIDTH (P_DATA_NBIT),
    .P_AW    (P_RDBUF_AW)
  ) u_rdbuf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_rdv_accept),
    .i_wdata (rdata),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = ~w_fifo_empty;
  assign out_data  = w_fifo_empty ? '0 : w_fifo_rdata;
  assign out_last  = ~w_fifo_empty && (r_ocnt == (r_len - LP_ONE));
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign wren      = r_wren;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign rd        = r_rd;
  assign raddr     = r_raddr;

endmodule
